// File: rtl/text_display_pkg.sv
// Glyph codes, active-low segment patterns and the code-to-segment decode
// shared by the multiplexed text display scanner.
package text_display_pkg;

  localparam int CODE_W = 18;
  localparam int SEG_W  = 7;

  // Glyph codes: two exact multi-bit codes, then one-hot codes by bit position
  localparam logic [CODE_W-1:0] CODE_BLANK = 18'b11;
  localparam logic [CODE_W-1:0] CODE_3     = 18'b111;
  localparam logic [CODE_W-1:0] CODE_A     = 18'h20000;
  localparam logic [CODE_W-1:0] CODE_B     = 18'h10000;
  localparam logic [CODE_W-1:0] CODE_C     = 18'h08000;
  localparam logic [CODE_W-1:0] CODE_D     = 18'h04000;
  localparam logic [CODE_W-1:0] CODE_E     = 18'h02000;
  localparam logic [CODE_W-1:0] CODE_F     = 18'h01000;
  localparam logic [CODE_W-1:0] CODE_G     = 18'h00800;
  localparam logic [CODE_W-1:0] CODE_H     = 18'h00400;
  localparam logic [CODE_W-1:0] CODE_I     = 18'h00200;
  localparam logic [CODE_W-1:0] CODE_L     = 18'h00100;
  localparam logic [CODE_W-1:0] CODE_N     = 18'h00080;
  localparam logic [CODE_W-1:0] CODE_O     = 18'h00040;
  localparam logic [CODE_W-1:0] CODE_P     = 18'h00020;
  localparam logic [CODE_W-1:0] CODE_R     = 18'h00010;
  localparam logic [CODE_W-1:0] CODE_T     = 18'h00008;
  localparam logic [CODE_W-1:0] CODE_U     = 18'h00004;
  localparam logic [CODE_W-1:0] CODE_Y     = 18'h00002;
  localparam logic [CODE_W-1:0] CODE_DASH  = 18'h00001;

  // Segment patterns, bit order {CG,CF,CE,CD,CC,CB,CA}, 0 = segment lit
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_G     = 7'h42;
  localparam logic [SEG_W-1:0] SEG_H     = 7'h09;
  localparam logic [SEG_W-1:0] SEG_I     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_L     = 7'h47;
  localparam logic [SEG_W-1:0] SEG_N     = 7'h2B;
  localparam logic [SEG_W-1:0] SEG_O     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_R     = 7'h2F;
  localparam logic [SEG_W-1:0] SEG_T     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_U     = 7'h41;
  localparam logic [SEG_W-1:0] SEG_Y     = 7'h11;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  // Exact-match decode; every code not listed (zero, other multi-bit) is blank
  function automatic logic [SEG_W-1:0] decode_glyph(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    case (code)
      CODE_BLANK: seg = SEG_BLANK;
      CODE_3:     seg = SEG_3;
      CODE_A:     seg = SEG_A;
      CODE_B:     seg = SEG_B;
      CODE_C:     seg = SEG_C;
      CODE_D:     seg = SEG_D;
      CODE_E:     seg = SEG_E;
      CODE_F:     seg = SEG_F;
      CODE_G:     seg = SEG_G;
      CODE_H:     seg = SEG_H;
      CODE_I:     seg = SEG_I;
      CODE_L:     seg = SEG_L;
      CODE_N:     seg = SEG_N;
      CODE_O:     seg = SEG_O;
      CODE_P:     seg = SEG_P;
      CODE_R:     seg = SEG_R;
      CODE_T:     seg = SEG_T;
      CODE_U:     seg = SEG_U;
      CODE_Y:     seg = SEG_Y;
      CODE_DASH:  seg = SEG_DASH;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/text_display_scan_seg_decode.sv
// Combinational glyph decoder: 18-bit glyph code to active-low segments.
module seg_decode
  import text_display_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);

  // Pure table lookup, no state
  assign o_seg = decode_glyph(i_code);

endmodule

// File: rtl/text_display_scan.sv
// Eight-digit multiplexed seven-segment scanner. A snapshot of all digit
// codes is taken once per frame so a frame never mixes old and new text;
// each digit slot starts with one blanked cycle to suppress ghosting.
module text_display_scan
  import text_display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 1024
) (
  input  logic              divided_clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] reg_d0,
  input  logic [CODE_W-1:0] reg_d1,
  input  logic [CODE_W-1:0] reg_d2,
  input  logic [CODE_W-1:0] reg_d3,
  input  logic [CODE_W-1:0] reg_d4,
  input  logic [CODE_W-1:0] reg_d5,
  input  logic [CODE_W-1:0] reg_d6,
  input  logic [CODE_W-1:0] reg_d7,
  output logic [7:0]        an,
  output logic [SEG_W-1:0]  seg,
  output logic              frame_tick
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;
  logic [CODE_W-1:0] r_snap [8];

  logic [CODE_W-1:0] w_din [8];
  logic              w_slot_start;
  logic              w_capture;
  logic              w_cnt_wrap;
  logic [CODE_W-1:0] w_code;
  logic [SEG_W-1:0]  w_seg;
  logic [7:0]        w_an_sel_n;

  assign w_din[0] = reg_d0;
  assign w_din[1] = reg_d1;
  assign w_din[2] = reg_d2;
  assign w_din[3] = reg_d3;
  assign w_din[4] = reg_d4;
  assign w_din[5] = reg_d5;
  assign w_din[6] = reg_d6;
  assign w_din[7] = reg_d7;

  assign w_slot_start = (r_cnt == '0);
  assign w_capture    = w_slot_start && (r_idx == 3'd0);
  assign w_cnt_wrap   = (r_cnt == CNT_LAST);
  assign w_code       = r_snap[r_idx];

  // One active-low anode select per digit position
  for (genvar gi = 0; gi < 8; gi++) begin : g_an_sel
    assign w_an_sel_n[gi] = (int'(r_idx) != gi);
  end

  seg_decode u_seg_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Slot counter and digit index; index steps only when the slot counter wraps
  always_ff @(posedge divided_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame snapshot: all eight codes latched together at the start of digit 0
  always_ff @(posedge divided_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_snap[i] <= CODE_BLANK;
    end else if (w_capture) begin
      for (int i = 0; i < 8; i++) r_snap[i] <= w_din[i];
    end
  end

  // Registered drive outputs; first cycle of every slot is fully blanked
  always_ff @(posedge divided_clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_capture;
      if (w_slot_start) begin
        an  <= 8'hFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= w_an_sel_n;
        seg <= w_seg;
      end
    end
  end

endmodule

// File: tb/tb_text_display_scan.sv
// Self-checking bench for text_display_scan with a behavioural scan model.
module tb_text_display_scan;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [17:0] d [8];
  logic [7:0]  an, an_l;
  logic [6:0]  seg, seg_l;
  logic        tick, tick_l;

  always #5 clk = ~clk;

  text_display_scan #(.DIGIT_CYCLES(D)) dut (
    .divided_clk(clk), .rst_n(rst_n),
    .reg_d0(d[0]), .reg_d1(d[1]), .reg_d2(d[2]), .reg_d3(d[3]),
    .reg_d4(d[4]), .reg_d5(d[5]), .reg_d6(d[6]), .reg_d7(d[7]),
    .an(an), .seg(seg), .frame_tick(tick)
  );

  text_display_scan dut_long (
    .divided_clk(clk), .rst_n(rst_n),
    .reg_d0(d[0]), .reg_d1(d[1]), .reg_d2(d[2]), .reg_d3(d[3]),
    .reg_d4(d[4]), .reg_d5(d[5]), .reg_d6(d[6]), .reg_d7(d[7]),
    .an(an_l), .seg(seg_l), .frame_tick(tick_l)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          e        = 0;   // rising edges since reset release
  logic [17:0] m_snap [8];
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_tick;

  // Active-low pattern from a list of lit segment letters a..g
  function automatic logic [6:0] lit(input string s);
    logic [6:0] v = 7'h7F;
    for (int k = 0; k < s.len(); k++) v[int'(s[k]) - 97] = 1'b0;
    return v;
  endfunction

  function automatic string glyph_segs(input int n);
    case (n)
      17: return "abcefg";  16: return "cdefg";  15: return "adef";
      14: return "bcdeg";   13: return "adefg";  12: return "aefg";
      11: return "acdef";   10: return "bcefg";  9:  return "bc";
      8:  return "def";     7:  return "ceg";    6:  return "abcdef";
      5:  return "abefg";   4:  return "eg";     3:  return "defg";
      2:  return "bcdef";   1:  return "bcdfg";  0:  return "g";
      default: return "";
    endcase
  endfunction

  function automatic logic [6:0] ref_decode(input logic [17:0] code);
    if (code == 18'b11)  return 7'h7F;
    if (code == 18'b111) return lit("abcdg");
    if ($countones(code) == 1)
      for (int n = 0; n < 18; n++) if (code[n]) return lit(glyph_segs(n));
    return 7'h7F;
  endfunction

  function automatic logic [17:0] onehot(input int n);
    logic [17:0] v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [17:0] rand_code();
    int r = int'($urandom_range(0, 21));
    if (r < 18)  return onehot(r);
    if (r == 18) return 18'b11;
    if (r == 19) return 18'b111;
    if (r == 20) return 18'h0;
    return 18'($urandom);
  endfunction

  // Advance one clock; expected outputs follow from the edge count alone:
  // cycle position s decides slot, digit and whether this edge captures.
  task automatic step();
    logic [17:0] pre [8];
    int s, c, i;
    pre = d;
    @(posedge clk);
    e++;
    s = e - 1;
    c = s % D;
    i = (s / D) % 8;
    if (c == 0) begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      exp_an  = ~(8'd1 << i);
      exp_seg = ref_decode(m_snap[i]);
    end
    exp_tick = ((s % FRAME) == 0);
    if (exp_tick) m_snap = pre;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    e = 0;
    for (int k = 0; k < 8; k++) m_snap[k] = 18'b11;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset: an=%h seg=%h tick=%b", an, seg, tick);
    n_checks++;
    if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an got=%h exp=ff", an); end
    n_checks++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_checks++;
    if (an_l !== 8'hFF || seg_l !== 7'h7F || tick_l !== 1'b0) begin
      n_fail++; $display("FAIL reset_long got=%h/%h/%b exp=ff/7f/0", an_l, seg_l, tick_l);
    end
  endtask

  task automatic test_basic();
    int t0 = -1, t1 = -1;
    d[7] = onehot(13); d[6] = onehot(15); d[5] = 18'b111; d[4] = onehot(9);
    d[3] = onehot(9);  d[2] = 18'b11;     d[1] = 18'b11;  d[0] = 18'b11;
    do_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || tick !== exp_tick) begin
        n_fail++;
        $display("FAIL basic e=%0d an=%h/%h seg=%h/%h tick=%b/%b", e, an, exp_an, seg, exp_seg, tick, exp_tick);
      end
      n_checks++;
      if ($countones(~an) > 1) begin n_fail++; $display("FAIL ghost e=%0d an=%h exp<=1 low", e, an); end
      if (tick === 1'b1) begin if (t0 < 0) t0 = e; else if (t1 < 0) t1 = e; end
      if (e == 2) begin
        n_checks++;
        if (an !== 8'hFE || seg !== 7'h7F) begin n_fail++; $display("FAIL digit0 an=%h seg=%h exp=fe/7f", an, seg); end
      end
      if (e == 4 * D + 2) begin
        n_checks++;
        if (an !== 8'hEF || seg !== lit("bc")) begin n_fail++; $display("FAIL digit4 an=%h seg=%h exp=ef/%h", an, seg, lit("bc")); end
      end
      if (e == 5 * D + 2) begin
        n_checks++;
        if (seg !== lit("abcdg")) begin n_fail++; $display("FAIL digit5 seg=%h exp=%h", seg, lit("abcdg")); end
      end
    end
    $display("basic: ticks at %0d and %0d", t0, t1);
    n_checks++;
    if (t0 != 1) begin n_fail++; $display("FAIL first_tick got=%0d exp=1", t0); end
    n_checks++;
    if (t1 - t0 != FRAME) begin n_fail++; $display("FAIL period got=%0d exp=%0d", t1 - t0, FRAME); end
  endtask

  task automatic test_tear();
    for (int k = 0; k < 7; k++) d[k] = rand_code();
    d[7] = onehot(12);
    do_reset();
    for (int k = 0; k < 80; k++) begin
      step();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || tick !== exp_tick) begin
        n_fail++;
        $display("FAIL tear e=%0d an=%h/%h seg=%h/%h tick=%b/%b", e, an, exp_an, seg, exp_seg, tick, exp_tick);
      end
      if (e == 10) d[7] = onehot(16);
      if (e == 7 * D + 2 || e == FRAME + 7 * D + 2) begin
        logic [6:0] want;
        want = (e < FRAME) ? lit("aefg") : lit("cdefg");
        $display("tear: e=%0d an=%h seg=%h", e, an, seg);
        n_checks++;
        if (an !== 8'h7F || seg !== want) begin n_fail++; $display("FAIL tear_d7 e=%0d an=%h seg=%h exp=7f/%h", e, an, seg, want); end
      end
    end
  endtask

  task automatic test_decode_sweep();
    for (int k = 0; k < 20; k++) begin
      logic [17:0] code;
      int guard;
      code = (k < 18) ? onehot(k) : ((k == 18) ? 18'h0 : 18'h3FFFF);
      d[0] = code;
      guard = 0;
      exp_tick = 1'b0;
      while (exp_tick !== 1'b1 && guard < 2 * FRAME) begin step(); guard++; end
      step();
      $display("sweep: code=%h an=%h seg=%h", code, an, seg);
      n_checks++;
      if (an !== 8'hFE || seg !== ref_decode(code) || guard >= 2 * FRAME) begin
        n_fail++;
        $display("FAIL sweep code=%h an=%h seg=%h exp=fe/%h", code, an, seg, ref_decode(code));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4 * FRAME; k++) begin
      step();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || tick !== exp_tick) begin
        n_fail++;
        $display("FAIL random e=%0d an=%h/%h seg=%h/%h tick=%b/%b", e, an, exp_an, seg, exp_seg, tick, exp_tick);
      end
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 7)] = rand_code();
    end
    $display("random: %0d cycles", 4 * FRAME);
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 8; k++) d[k] = rand_code();
    do_reset();
    while (e < 5 * D + 2) begin
      step();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || tick !== exp_tick) begin
        n_fail++;
        $display("FAIL midrun e=%0d an=%h/%h seg=%h/%h", e, an, exp_an, seg, exp_seg);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    $display("midreset: an=%h seg=%h tick=%b", an, seg, tick);
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || tick !== 1'b0) begin
      n_fail++; $display("FAIL async_blank an=%h seg=%h tick=%b exp=ff/7f/0", an, seg, tick);
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) d[k] = onehot(int'($urandom_range(0, 17)));
    e = 0;
    for (int k = 0; k < 8; k++) m_snap[k] = 18'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < FRAME + 4; k++) begin
      step();
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || tick !== exp_tick) begin
        n_fail++;
        $display("FAIL restart e=%0d an=%h/%h seg=%h/%h tick=%b/%b", e, an, exp_an, seg, exp_seg, tick, exp_tick);
      end
      if (e == 2) begin
        n_checks++;
        if (an !== 8'hFE || seg !== ref_decode(d[0])) begin
          n_fail++; $display("FAIL restart_d0 an=%h seg=%h exp=fe/%h", an, seg, ref_decode(d[0]));
        end
      end
    end
  endtask

  task automatic test_long_period();
    int cyc = 0, nt = 0;
    int tt [4];
    do_reset();
    while (nt < 4 && cyc < 30000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tick_l === 1'b1) begin tt[nt] = cyc; nt++; end
    end
    $display("long: %0d ticks in %0d cycles", nt, cyc);
    n_checks++;
    if (nt != 4) begin
      n_fail++; $display("FAIL long_ticks got=%0d exp=4", nt);
    end else begin
      n_checks++;
      if (tt[0] != 1) begin n_fail++; $display("FAIL long_first got=%0d exp=1", tt[0]); end
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (tt[k] - tt[k-1] != 8192) begin
          n_fail++; $display("FAIL long_spacing%0d got=%0d exp=8192", k, tt[k] - tt[k-1]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin d[k] = 18'b11; m_snap[k] = 18'b11; end
    test_reset();
    test_basic();
    test_tear();
    test_decode_sweep();
    test_random();
    test_reset_midframe();
    test_long_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
